// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the audio flash fetch path.
package audio_pkg;

  localparam int                ADDR_W      = 24;
  localparam int                DATA_W      = 8;
  localparam logic [ADDR_W-1:0] FLASH_START = 24'h000000;
  localparam logic [ADDR_W-1:0] FLASH_END   = 24'h1FFFFF;
  localparam int                SAMPLE_DIV  = 2268;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/audio_fetch_sequencer_tick_gen.sv
// Sample-rate divider: one-cycle tick every DIV clocks, held at zero while clr is high.
module sample_tick_gen #(
  parameter int DIV = 2268
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/audio_fetch_sequencer.sv
// Walks the audio flash region one byte per sample tick, keeping one sample prefetched
// ahead of the PWM stage.
module audio_fetch_sequencer #(
  parameter int                        ADDR_W     = audio_pkg::ADDR_W,
  parameter int                        DATA_W     = audio_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]         START_ADDR = audio_pkg::FLASH_START,
  parameter logic [ADDR_W-1:0]         END_ADDR   = audio_pkg::FLASH_END,
  parameter int                        SAMPLE_DIV = audio_pkg::SAMPLE_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              loop,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              playing,
  output logic              done,
  output logic              underrun
);

  import audio_pkg::*;

  fetch_state_e      state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] smp_buf;
  logic              buf_full;
  logic              enable_q;
  logic              tick;
  logic              div_clr;

  assign div_clr = (state == IDLE) || (state == DONE);
  assign rd_addr = addr;

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .tick  (tick)
  );

  // Prefetch buffer is pure data; only a retained (enabled) ack loads it.
  always_ff @(posedge clk) begin
    if ((state == FETCH) && rd_ack && enable) begin
      smp_buf <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= START_ADDR;
      rd_req       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      playing      <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
      buf_full     <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      enable_q     <= enable;
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state    <= FETCH;
            rd_req   <= 1'b1;
            playing  <= 1'b1;
            underrun <= 1'b0;
          end
        end
        FETCH: begin
          // An ack in the same cycle as a tick wins, so that tick is not an underrun.
          if (rd_ack) begin
            rd_req <= 1'b0;
            if (enable) begin
              state    <= HOLD;
              buf_full <= 1'b1;
            end else begin
              state   <= IDLE;
              playing <= 1'b0;
            end
          end else if (tick) begin
            underrun <= 1'b1;
          end
        end
        HOLD: begin
          if (!enable) begin
            state    <= IDLE;
            buf_full <= 1'b0;
            playing  <= 1'b0;
          end else if (tick && buf_full) begin
            sample_out   <= smp_buf;
            sample_valid <= 1'b1;
            buf_full     <= 1'b0;
            if (addr == END_ADDR) begin
              if (loop) begin
                addr   <= START_ADDR;
                state  <= FETCH;
                rd_req <= 1'b1;
              end else begin
                state   <= DONE;
                done    <= 1'b1;
                playing <= 1'b0;
              end
            end else begin
              addr   <= addr + 1'b1;
              state  <= FETCH;
              rd_req <= 1'b1;
            end
          end
        end
        DONE: begin
          if (enable && !enable_q) begin
            addr    <= START_ADDR;
            done    <= 1'b0;
            state   <= FETCH;
            rd_req  <= 1'b1;
            playing <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_fetch_sequencer.sv
// Bench for audio_fetch_sequencer: flash responder, behavioural player model, directed and random play.
module tb_audio_fetch_sequencer;

  localparam int          DIV = 8;
  localparam logic [23:0] SA  = 24'd4;
  localparam logic [23:0] EA  = 24'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        loop = 1'b0;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        playing;
  logic        done;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int ack_delay = 2;
  bit rand_mode = 1'b0;

  logic [7:0] vq[$];
  int         vc[$];
  logic [7:0] exp2[5] = '{8'h14, 8'h15, 8'h16, 8'h14, 8'h15};

  // Model: run 0 = stopped, 1 = playing, 2 = finished
  int          m_run = 0;
  int          play_start = 0;
  bit          m_req = 1'b0;
  bit          m_en_prev = 1'b0;
  logic [23:0] m_addr = SA;
  logic [7:0]  m_buf = 8'h00;
  logic [7:0]  e_sample = 8'h00;
  bit          e_valid = 1'b0;
  bit          e_underrun = 1'b0;
  bit          e_done = 1'b0;

  audio_fetch_sequencer #(
    .ADDR_W     (24),
    .DATA_W     (8),
    .START_ADDR (SA),
    .END_ADDR   (EA),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .loop         (loop),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .playing      (playing),
    .done         (done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_play();
    vq.delete();
    vc.delete();
    t0     = cyc;
    enable = 1'b1;
  endtask

  task automatic wait_valid(input int n, input int bound);
    for (int i = 0; i < bound && vq.size() < n; i++) step();
    chk("wait_valid_count", vq.size() >= n ? n : vq.size(), n);
  endtask

  // Flash reader: acks each request after a programmable number of cycles.
  initial begin
    int wcnt;
    int cur_delay;
    wcnt = 0;
    cur_delay = 1;
    forever begin
      @(negedge clk);
      rd_ack = 1'b0;
      if (rst_n && rd_req) begin
        if (wcnt == 0) cur_delay = rand_mode ? int'($urandom_range(1, 14)) : ack_delay;
        wcnt++;
        if (wcnt >= cur_delay) begin
          rd_ack  = 1'b1;
          rd_data = rand_mode ? 8'($urandom) : 8'(rd_addr[7:0] + 8'h10);
          wcnt    = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Player model, advanced once per clock from the inputs seen in that cycle.
  always @(posedge clk) begin
    bit tk;
    if (!rst_n) begin
      m_run = 0; m_req = 1'b0; m_addr = SA; m_en_prev = 1'b0;
      e_sample = 8'h00; e_valid = 1'b0; e_underrun = 1'b0; e_done = 1'b0;
    end else begin
      tk = (m_run == 1) && (((cyc - play_start) % DIV) == DIV - 1);
      e_valid = 1'b0;
      if (m_run == 0) begin
        if (enable) begin
          m_run = 1; play_start = cyc + 1; m_req = 1'b1; e_underrun = 1'b0;
        end
      end else if (m_run == 2) begin
        if (enable && !m_en_prev) begin
          m_run = 1; play_start = cyc + 1; m_addr = SA; m_req = 1'b1; e_done = 1'b0;
        end
      end else if (m_req) begin
        if (rd_ack) begin
          m_req = 1'b0;
          if (enable) m_buf = rd_data;
          else m_run = 0;
        end else if (tk) begin
          e_underrun = 1'b1;
        end
      end else if (!enable) begin
        m_run = 0;
      end else if (tk) begin
        e_sample = m_buf;
        e_valid  = 1'b1;
        if (m_addr == EA) begin
          if (loop) begin m_addr = SA; m_req = 1'b1; end
          else begin m_run = 2; e_done = 1'b1; end
        end else begin
          m_addr = m_addr + 24'd1;
          m_req  = 1'b1;
        end
      end
      m_en_prev = enable;
    end
    cyc++;
  end

  // Compare DUT against the model every cycle out of reset, and log emitted samples.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_req", rd_req, m_req);
      chk("rd_addr", rd_addr, m_addr);
      chk("sample_valid", sample_valid, e_valid);
      chk("sample_out", sample_out, e_sample);
      chk("playing", playing, m_run == 1);
      chk("done", done, e_done);
      chk("underrun", underrun, e_underrun);
      if (sample_valid === 1'b1) begin
        vq.push_back(sample_out);
        vc.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then an asynchronous reset in the middle of a fetch
    step();
    step();
    chk("rst_req", rd_req, 0);
    chk("rst_addr", rd_addr, 4);
    chk("rst_flags", {sample_valid, playing, done, underrun}, 0);
    chk("rst_sample", sample_out, 0);
    rst_n = 1'b1;
    ack_delay = 5;
    loop = 1'b1;
    enable = 1'b1;
    step();
    step();
    chk("t1_req_before", rd_req, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_req", rd_req, 0);
    chk("t1_addr", rd_addr, 4);
    chk("t1_flags", {sample_valid, playing, done, underrun}, 0);
    enable = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Looping playback, ack two cycles after request
    ack_delay = 2;
    loop = 1'b1;
    start_play();
    wait_valid(5, 70);
    for (int i = 0; i < 5 && i < vq.size(); i++) chk("t2_value", vq[i], exp2[i]);
    if (vc.size() > 0) chk("t2_first_latency", vc[0] - t0, 9);
    for (int i = 1; i < 5 && i < vc.size(); i++) chk("t2_spacing", vc[i] - vc[i-1], 8);
    chk("t2_underrun", underrun, 0);

    // One-shot playback stops after the last address
    do_reset();
    loop = 1'b0;
    start_play();
    for (int i = 0; i < 60 && done !== 1'b1; i++) step();
    chk("t3_done", done, 1);
    chk("t3_count", vq.size(), 3);
    for (int i = 0; i < 3 && i < vq.size(); i++) chk("t3_value", vq[i], exp2[i]);
    chk("t3_playing", playing, 0);
    chk("t3_req", rd_req, 0);
    repeat (10) step();
    chk("t3_no_more", vq.size(), 3);
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    chk("t3_restart_req", rd_req, 1);
    chk("t3_restart_addr", rd_addr, 4);
    chk("t3_restart_done", done, 0);

    // Slow flash: first tick lands in FETCH
    do_reset();
    loop = 1'b1;
    ack_delay = 12;
    start_play();
    repeat (10) step();
    chk("t4_underrun", underrun, 1);
    chk("t4_no_valid", vq.size(), 0);
    wait_valid(1, 40);
    if (vq.size() > 0) chk("t4_value", vq[0], 8'h14);
    if (vc.size() > 0) chk("t4_latency", vc[0] - t0, 17);

    // Disable while a request is outstanding, then resume
    do_reset();
    loop = 1'b1;
    ack_delay = 4;
    start_play();
    wait_valid(1, 30);
    chk("t5_req_addr5", rd_addr, 5);
    enable = 1'b0;
    step();
    chk("t5_req_held", rd_req, 1);
    for (int i = 0; i < 20 && rd_req !== 1'b0; i++) step();
    chk("t5_req_dropped", rd_req, 0);
    chk("t5_idle", playing, 0);
    chk("t5_addr_kept", rd_addr, 5);
    enable = 1'b1;
    step();
    chk("t5_resume_req", rd_req, 1);
    chk("t5_resume_addr", rd_addr, 5);

    // Ack coincides with a tick
    do_reset();
    ack_delay = 8;
    start_play();
    repeat (12) step();
    chk("t6_underrun", underrun, 0);
    wait_valid(1, 30);
    if (vq.size() > 0) chk("t6_value", vq[0], 8'h14);
    if (vc.size() > 0) chk("t6_latency", vc[0] - t0, 17);
    chk("t6_underrun_after", underrun, 0);

    // Random enable/loop toggling with random flash latency and data
    do_reset();
    rand_mode = 1'b1;
    enable = 1'b1;
    repeat (1500) begin
      step();
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if ($urandom_range(0, 99) < 2) loop = ~loop;
    end
    enable = 1'b0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
